// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - MIPS instruction-fetch stage: PC register, redirect selection, IF/ID register
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset_sh,
    input  logic [31:0] branch_pc_plus4,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        redirect_pending
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pending, pending_nx;
    logic [31:0] instr_nx, pp4_nx;
    logic        valid_nx;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target, jump_target, jr_aligned, live_target;
    logic        redirect;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = branch_pc_plus4 + branch_offset_sh;
    assign jump_target   = {ifid_pc_plus4[31:28], jump_index, 2'b00};
    assign jr_aligned    = jr_target & 32'hFFFF_FFFC;
    assign redirect      = jr | jump | branch_taken;

    // jr outranks jump, which outranks a taken branch
    assign live_target = jr   ? jr_aligned  :
                         jump ? jump_target : branch_target;

    assign imem_addr        = pc;
    assign redirect_pending = (state == HOLD);

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        pending_nx = pending;
        instr_nx   = ifid_instr;
        pp4_nx     = ifid_pc_plus4;
        valid_nx   = ifid_valid;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (redirect) begin
                        pc_nx    = live_target;
                        instr_nx = NOP_INSTR;
                        pp4_nx   = 32'd0;
                        valid_nx = 1'b0;
                    end else begin
                        pc_nx    = pc_plus4;
                        instr_nx = imem_data;
                        pp4_nx   = pc_plus4;
                        valid_nx = 1'b1;
                    end
                end else if (redirect) begin
                    pending_nx = live_target;
                    state_nx   = HOLD;
                end
            end
            HOLD: begin
                if (stall) begin
                    if (redirect) pending_nx = live_target;
                end else begin
                    // a redirect arriving on release is younger than the held one
                    pc_nx    = redirect ? live_target : pending;
                    instr_nx = NOP_INSTR;
                    pp4_nx   = 32'd0;
                    valid_nx = 1'b0;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            pending       <= 32'd0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
        end else begin
            state         <= state_nx;
            pc            <= pc_nx;
            pending       <= pending_nx;
            ifid_instr    <= instr_nx;
            ifid_pc_plus4 <= pp4_nx;
            ifid_valid    <= valid_nx;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - randomized and directed self-checking bench for pc_fetch_stage
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_offset_sh = 32'd0;
    logic [31:0] branch_pc_plus4 = 32'd0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = 26'd0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] ifid_instr, ifid_pc_plus4;
    logic        ifid_valid, redirect_pending;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_pp4, m_pend;
    logic        m_valid, m_has_pend;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    assign imem_data = mem_word(imem_addr);

    pc_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_offset_sh(branch_offset_sh),
        .branch_pc_plus4(branch_pc_plus4), .jump(jump), .jump_index(jump_index),
        .jr(jr), .jr_target(jr_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
        .redirect_pending(redirect_pending)
    );

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0;
        m_pend = 32'h0; m_has_pend = 1'b0;
    endtask

    // one clock of the fetch stage, described in terms of what the pipeline should do
    task automatic model_edge();
        logic [31:0] tgt;
        logic        redir;
        redir = jr | jump | branch_taken;
        if (jr)        tgt = {jr_target[31:2], 2'b00};
        else if (jump) tgt = {m_pp4[31:28], jump_index, 2'b00};
        else           tgt = branch_pc_plus4 + branch_offset_sh;
        if (stall) begin
            if (redir) begin m_pend = tgt; m_has_pend = 1'b1; end
        end else if (redir || m_has_pend) begin
            m_pc = redir ? tgt : m_pend;
            m_instr = NOP; m_pp4 = 32'h0; m_valid = 1'b0; m_has_pend = 1'b0;
        end else begin
            m_instr = mem_word(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic apply(input logic s, input logic bt, input logic [31:0] bpp4,
                         input logic [31:0] off, input logic j, input logic [25:0] idx,
                         input logic r, input logic [31:0] rt);
        stall = s; branch_taken = bt; branch_pc_plus4 = bpp4; branch_offset_sh = off;
        jump = j; jump_index = idx; jr = r; jr_target = rt;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", imem_addr, 32'h0); end
        n_vec++; if (ifid_instr !== NOP) begin n_err++; $display("FAIL reset_instr got %h want %h", ifid_instr, NOP); end
        n_vec++; if ({ifid_valid, redirect_pending} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {ifid_valid, redirect_pending}); end
        n_vec++; if (ifid_pc_plus4 !== 32'h0) begin n_err++; $display("FAIL reset_pp4 got %h want 0", ifid_pc_plus4); end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            idle();
            n_vec++; if (imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL freerun_addr%0d got %h want %h", k, imem_addr, 32'(4 * k)); end
            n_vec++; if (ifid_pc_plus4 !== 32'(4 * k) || ifid_valid !== 1'b1) begin n_err++; $display("FAIL freerun_ifid%0d got %h/%b want %h/1", k, ifid_pc_plus4, ifid_valid, 32'(4 * k)); end
            n_vec++; if (ifid_instr !== mem_word(32'(4 * k - 4))) begin n_err++; $display("FAIL freerun_instr%0d got %h want %h", k, ifid_instr, mem_word(32'(4 * k - 4))); end
        end
    endtask

    task automatic test_branch();
        apply(1'b0, 1'b1, 32'h40, 32'hFFFF_FFF0, 1'b0, 26'h0, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h30) begin n_err++; $display("FAIL branch_addr got %h want %h", imem_addr, 32'h30); end
        n_vec++; if (ifid_instr !== NOP || ifid_valid !== 1'b0) begin n_err++; $display("FAIL branch_flush got %h/%b want %h/0", ifid_instr, ifid_valid, NOP); end
        idle();
        n_vec++; if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h34) begin n_err++; $display("FAIL branch_after got %b/%h want 1/%h", ifid_valid, ifid_pc_plus4, 32'h34); end
    endtask

    task automatic test_jr_priority();
        apply(1'b0, 1'b1, 32'h80, 32'h8, 1'b1, 26'h3FF, 1'b1, 32'h0000_1003);
        n_vec++; if (imem_addr !== 32'h1000) begin n_err++; $display("FAIL jr_priority got %h want %h", imem_addr, 32'h1000); end
    endtask

    // park the PC at 0x1000_0000 and fetch once so IF/ID holds PC+4 = 0x1000_0004
    task automatic seed_region();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h1000_0000);
        idle();
    endtask

    task automatic test_stall_hold();
        seed_region();
        apply(1'b1, 1'b1, 32'h1F0, 32'h10, 1'b0, 26'h0, 1'b0, 32'h0);
        n_vec++; if (redirect_pending !== 1'b1 || imem_addr !== 32'h1000_0004) begin n_err++; $display("FAIL stall_c1 got %b/%h want 1/%h", redirect_pending, imem_addr, 32'h1000_0004); end
        for (int c = 2; c <= 3; c++) begin
            apply(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
            n_vec++; if (redirect_pending !== 1'b1 || imem_addr !== 32'h1000_0004 || ifid_pc_plus4 !== 32'h1000_0004 || ifid_valid !== 1'b1) begin
                n_err++; $display("FAIL stall_c%0d got %b/%h/%h/%b want 1/10000004/10000004/1", c, redirect_pending, imem_addr, ifid_pc_plus4, ifid_valid);
            end
        end
        idle();
        n_vec++; if (imem_addr !== 32'h200 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL stall_release got %h/%b want %h/0", imem_addr, redirect_pending, 32'h200); end
    endtask

    task automatic test_hold_live_wins();
        seed_region();
        apply(1'b1, 1'b1, 32'h1F0, 32'h10, 1'b0, 26'h0, 1'b0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 26'h40, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h1000_0100 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL hold_jump got %h/%b want %h/0", imem_addr, redirect_pending, 32'h1000_0100); end
        idle();
        n_vec++; if (imem_addr !== 32'h1000_0104) begin n_err++; $display("FAIL hold_discard got %h want %h", imem_addr, 32'h1000_0104); end
    endtask

    task automatic test_async_reset();
        seed_region();
        apply(1'b1, 1'b1, 32'h1F0, 32'h10, 1'b0, 26'h0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (imem_addr !== 32'h0 || redirect_pending !== 1'b0 || ifid_valid !== 1'b0) begin n_err++; $display("FAIL async_reset got %h/%b/%b want 0/0/0", imem_addr, redirect_pending, ifid_valid); end
        stall = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        n_vec++; if (imem_addr !== 32'h4 || redirect_pending !== 1'b0) begin n_err++; $display("FAIL after_reset got %h/%b want 4/0", imem_addr, redirect_pending); end
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFF);
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got %h want fffffffc", imem_addr); end
        idle();
        n_vec++; if (imem_addr !== 32'h0 || ifid_pc_plus4 !== 32'h0 || ifid_valid !== 1'b1) begin n_err++; $display("FAIL wrap got %h/%h/%b want 0/0/1", imem_addr, ifid_pc_plus4, ifid_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) == 0, 26'($urandom), $urandom_range(0, 19) == 0, $urandom);
            n_vec++;
            if (imem_addr !== m_pc || ifid_instr !== m_instr || ifid_pc_plus4 !== m_pp4 ||
                ifid_valid !== m_valid || redirect_pending !== m_has_pend) begin
                n_err++;
                $display("FAIL random%0d got %h/%h/%h/%b/%b want %h/%h/%h/%b/%b", i,
                         imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, redirect_pending,
                         m_pc, m_instr, m_pp4, m_valid, m_has_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jr_priority();
        test_stall_hold();
        test_hold_live_wins();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
